// File: rtl/moving_avg_pkg.sv
// Shared sizing and packing helpers for the moving-average filter.
package moving_avg_pkg;

  function automatic int sum_width(input int width, input int log2_depth);
    return width + log2_depth;
  endfunction

  // Half of the divisor, added before the final shift when rounding is enabled.
  function automatic int round_const(input int round, input int log2_depth);
    return (round != 0 && log2_depth > 0) ? (1 << (log2_depth - 1)) : 0;
  endfunction

  function automatic int chan_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/moving_avg_channel.sv
// One channel of the boxcar filter: sample window storage, S1/S2 registers and running sum.
// Pointer, fill state and valid pipeline come from the top so all channels stay in lock-step.
module moving_avg_channel
  import moving_avg_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LOG2_DEPTH = 5,
  parameter int ROUND      = 0
) (
  input  logic                  clk,
  input  logic                  flush,
  input  logic                  bypass,
  input  logic [WIDTH-1:0]      in,
  input  logic                  accept,
  input  logic [LOG2_DEPTH-1:0] wptr,
  input  logic                  fill_full,
  input  logic                  s2_valid,
  output logic [WIDTH-1:0]      out
);

  localparam int DEPTH = 2 ** LOG2_DEPTH;
  localparam int SW    = sum_width(WIDTH, LOG2_DEPTH);
  localparam logic [SW-1:0] RND = SW'(round_const(ROUND, LOG2_DEPTH));

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] new_r;
  logic [WIDTH-1:0] old_r;
  logic [SW-1:0]    sum;
  logic [SW-1:0]    sum_next;
  logic [WIDTH-1:0] avg;

  // Storage is deliberately left unreset; stale entries are masked by fill_full below.
  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= in;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      new_r <= '0;
      old_r <= '0;
    end else if (accept) begin
      new_r <= in;
      old_r <= fill_full ? mem[wptr] : '0;
    end
  end

  assign sum_next = sum + SW'(new_r) - SW'(old_r);
  assign avg      = WIDTH'((sum_next + RND) >> LOG2_DEPTH);

  always_ff @(posedge clk) begin
    if (flush) begin
      sum <= '0;
      out <= '0;
    end else if (s2_valid) begin
      sum <= sum_next;
      out <= bypass ? new_r : avg;
    end
  end

endmodule

// File: rtl/moving_avg_filter.sv
// Multi-channel running-sum moving-average filter, 2-cycle in_valid -> out_valid latency.
// Owns the shared write pointer, fill counter, primed flag and valid pipeline.
module moving_avg_filter
  import moving_avg_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LOG2_DEPTH = 5,
  parameter int CHANNELS   = 1,
  parameter int ROUND      = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      bypass,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic                      in_valid,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic                      out_valid,
  output logic                      primed
);

  if (LOG2_DEPTH < 1 || LOG2_DEPTH > 8) begin : g_bad_depth
    $error("moving_avg_filter: LOG2_DEPTH must be in 1..8");
  end

  logic                  flush;
  logic                  accept;
  logic                  fill_full;
  logic                  s1_valid;
  logic [LOG2_DEPTH-1:0] wptr;
  logic [LOG2_DEPTH:0]   fill;
  logic [LOG2_DEPTH:0]   fill_next;

  assign flush     = reset | clear;
  assign accept    = in_valid & ~flush;
  // DEPTH is a power of two, so the top fill bit alone means "window full".
  assign fill_full = fill[LOG2_DEPTH];
  assign fill_next = fill_full ? fill : fill + (LOG2_DEPTH + 1)'(1);

  always_ff @(posedge clk) begin
    if (flush) begin
      wptr      <= '0;
      fill      <= '0;
      primed    <= 1'b0;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_valid  <= accept;
      out_valid <= s1_valid;
      if (accept) begin
        wptr   <= wptr + LOG2_DEPTH'(1);
        fill   <= fill_next;
        primed <= fill_next[LOG2_DEPTH];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    moving_avg_channel #(
      .WIDTH      (WIDTH),
      .LOG2_DEPTH (LOG2_DEPTH),
      .ROUND      (ROUND)
    ) u_ch (
      .clk       (clk),
      .flush     (flush),
      .bypass    (bypass),
      .in        (in[chan_lsb(g, WIDTH) +: WIDTH]),
      .accept    (accept),
      .wptr      (wptr),
      .fill_full (fill_full),
      .s2_valid  (s1_valid),
      .out       (out[chan_lsb(g, WIDTH) +: WIDTH])
    );
  end

endmodule

// File: tb/tb_moving_avg_filter.sv
// Scoreboard bench: DUT a is 2-channel depth-4 truncating, DUT b is 1-channel depth-4 rounding.
module tb_moving_avg_filter;

  typedef struct {
    logic [15:0] dat;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        bypass = 1'b0;
  logic        b_bypass = 1'b0;
  logic [15:0] a_in = '0;
  logic        a_in_valid = 1'b0;
  logic [15:0] a_out;
  logic        a_out_valid;
  logic        a_primed;
  logic [7:0]  b_in = '0;
  logic        b_in_valid = 1'b0;
  logic [7:0]  b_out;
  logic        b_out_valid;
  logic        b_primed;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [15:0] last_a = '0;
  logic        prev_flush = 1'b1;

  int e2[12] = '{63, 127, 191, 255, 255, 255, 191, 127, 63, 0, 0, 0};
  int e4_0[6] = '{25, 50, 75, 100, 100, 100};
  int e4_1[6] = '{10, 20, 30, 40, 40, 40};
  int s3[4]  = '{1, 1, 0, 0};
  int e3b[4] = '{0, 1, 1, 1};

  moving_avg_filter #(.WIDTH(8), .LOG2_DEPTH(2), .CHANNELS(2), .ROUND(0)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .bypass(bypass),
    .in(a_in), .in_valid(a_in_valid),
    .out(a_out), .out_valid(a_out_valid), .primed(a_primed)
  );

  moving_avg_filter #(.WIDTH(8), .LOG2_DEPTH(2), .CHANNELS(1), .ROUND(1)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .bypass(b_bypass),
    .in(b_in), .in_valid(b_in_valid),
    .out(b_out), .out_valid(b_out_valid), .primed(b_primed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Monitor: pops expected data and arrival cycle on every strobe; out must hold otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (a_out_valid) begin
      total++;
      if (qa.size() == 0) begin
        bad++;
        $display("FAIL a_spurious got=%h want=no_strobe", a_out);
      end else begin
        e = qa.pop_front();
        if (a_out !== e.dat || cyc != e.cyc) begin
          bad++;
          $display("FAIL a_out got=%h@%0d want=%h@%0d", a_out, cyc, e.dat, e.cyc);
        end
      end
    end else if (!(reset || clear || prev_flush)) begin
      total++;
      if (a_out !== last_a) begin
        bad++;
        $display("FAIL a_hold got=%h want=%h", a_out, last_a);
      end
    end
    if (b_out_valid) begin
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL b_spurious got=%h want=no_strobe", b_out);
      end else begin
        e = qb.pop_front();
        if (b_out !== e.dat[7:0] || cyc != e.cyc) begin
          bad++;
          $display("FAIL b_out got=%h@%0d want=%h@%0d", b_out, cyc, e.dat[7:0], e.cyc);
        end
      end
    end
    last_a     = a_out;
    prev_flush = reset || clear;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Called at a negedge; drives one sample for the coming edge and returns at the next negedge.
  task automatic send_a(input logic [7:0] s1, input logic [7:0] s0,
                        input logic [7:0] e1, input logic [7:0] e0, input bit exp_out);
    a_in       = {s1, s0};
    a_in_valid = 1'b1;
    if (exp_out) qa.push_back('{dat: {e1, e0}, cyc: cyc + 2});
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  task automatic send1(input logic [7:0] s, input logic [7:0] e, input bit exp_out);
    send_a(s, s, e, e, exp_out);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_a_out", int'(a_out), 0);
    check("rst_a_valid", int'(a_out_valid), 0);
    check("rst_a_primed", int'(a_primed), 0);
    check("rst_b_out", int'(b_out), 0);
    check("rst_b_primed", int'(b_primed), 0);

    // Ramp-up, priming and oldest-sample subtraction
    send1(8'd4, 8'd1, 1);
    send1(8'd8, 8'd3, 1);
    send1(8'd12, 8'd6, 1);
    check("t1_primed_after3", int'(a_primed), 0);
    send1(8'd16, 8'd10, 1);
    check("t1_primed_after4", int'(a_primed), 1);
    send1(8'd20, 8'd14, 1);
    repeat (3) @(negedge clk);

    // Full-scale saturation and decay
    do_reset();
    for (int i = 0; i < 12; i++) send1((i < 6) ? 8'd255 : 8'd0, 8'(e2[i]), 1);
    repeat (3) @(negedge clk);

    // Rounding (dut_b) vs truncation (dut_a) on identical input
    do_reset();
    for (int i = 0; i < 4; i++) begin
      b_in       = 8'(s3[i]);
      b_in_valid = 1'b1;
      qb.push_back('{dat: 16'(e3b[i]), cyc: cyc + 2});
      send1(8'(s3[i]), 8'd0, 1);
      b_in_valid = 1'b0;
    end
    check("t3_b_primed", int'(b_primed), 1);
    repeat (3) @(negedge clk);

    // Independent channels, in_valid every other cycle
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send_a(8'd40, 8'd100, 8'(e4_1[i]), 8'(e4_0[i]), 1);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);

    // Clear with in_valid drops both the new and the in-flight sample
    do_reset();
    send1(8'd4, 8'd1, 1);
    send1(8'd4, 8'd2, 1);
    send1(8'd4, 8'd0, 0);
    clear = 1'b1;
    send1(8'd200, 8'd0, 0);
    clear = 1'b0;
    check("t5_clr_primed", int'(a_primed), 0);
    check("t5_clr_out", int'(a_out), 0);
    check("t5_clr_valid", int'(a_out_valid), 0);
    send1(8'd8, 8'd2, 1);
    send1(8'd8, 8'd4, 1);
    send1(8'd8, 8'd6, 1);
    send1(8'd8, 8'd8, 1);
    repeat (3) @(negedge clk);

    // Bypass passes raw samples while the sum keeps tracking
    do_reset();
    bypass = 1'b1;
    send1(8'd10, 8'd10, 1);
    send1(8'd20, 8'd20, 1);
    send1(8'd30, 8'd30, 1);
    send1(8'd40, 8'd40, 1);
    @(negedge clk);
    bypass = 1'b0;
    send1(8'd50, 8'd35, 1);
    check("t6_primed", int'(a_primed), 1);

    repeat (4) @(negedge clk);
    check("drain_qa", qa.size(), 0);
    check("drain_qb", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
